// File: rtl/alu_seq.sv
// Handshaked integer/float-sign ALU with iterative shift-add multiply.
// Define ALU_SEQ_DIV_EN to add the restoring divider (DIVU/REMU, opcodes 10/11).
module alu_seq #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   op,
  input  logic [W-1:0] val1,
  input  logic [W-1:0] val2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         illegal
);
  localparam int SH = $clog2(W);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t          state;
  logic [SH-1:0]   cnt;
  logic [2*W-1:0]  acc;
  logic [W-1:0]    opnd;
  logic            sel_hi;
  logic            accept;
  logic            is_mul;
  logic [W-1:0]    alu_res;
  logic            alu_ill;
  logic [W:0]      mul_sum;
  logic [2*W-1:0]  mul_next;

  assign in_ready = (state == IDLE) & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign is_mul   = (op == 4'd8) || (op == 4'd9);

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (op)
      4'd0:    alu_res = val1 + val2;
      4'd1:    alu_res = val1 - val2;
      4'd2:    alu_res = val1 << val2[SH-1:0];
      4'd3:    alu_res = val1 >> val2[SH-1:0];
      4'd4:    alu_res = $signed(val1) >>> val2[SH-1:0];
      4'd5:    alu_res = {{(W-1){1'b0}}, ~val2[W-1]};
      4'd6:    alu_res = {{(W-1){1'b0}}, val2[W-1]};
      4'd7:    alu_res = {~val2[W-1], val2[W-2:0]};
      default: alu_ill = 1'b1;
    endcase
  end

  // acc = {partial product high, remaining multiplier bits}; consume LSB each cycle
  assign mul_sum  = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? opnd : {W{1'b0}})};
  assign mul_next = {mul_sum, acc[W-1:1]};

`ifdef ALU_SEQ_DIV_EN
  logic           is_div;
  logic [W:0]     div_sh;
  logic           div_ge;
  logic [W-1:0]   div_rem;
  logic [2*W-1:0] div_next;

  assign is_div = (op == 4'd10) || (op == 4'd11);
  // acc = {partial remainder, dividend shifting out / quotient shifting in}.
  // A zero divisor always "fits", which yields all-ones quotient and rem = dividend.
  assign div_sh   = {acc[2*W-1:W], acc[W-1]};
  assign div_ge   = div_sh >= {1'b0, opnd};
  assign div_rem  = div_ge ? (div_sh[W-1:0] - opnd) : div_sh[W-1:0];
  assign div_next = {div_rem, acc[W-2:0], div_ge};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      opnd      <= '0;
      sel_hi    <= 1'b0;
      result    <= '0;
      illegal   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_mul) begin
              acc    <= {{W{1'b0}}, val2};
              opnd   <= val1;
              sel_hi <= op[0];
              cnt    <= '0;
              state  <= MUL;
            end
`ifdef ALU_SEQ_DIV_EN
            else if (is_div) begin
              acc    <= {{W{1'b0}}, val1};
              opnd   <= val2;
              sel_hi <= op[0];
              cnt    <= '0;
              state  <= DIV;
            end
`endif
            else begin
              result    <= alu_res;
              illegal   <= alu_ill;
              out_valid <= 1'b1;
            end
          end
        end
        MUL: begin
          acc <= mul_next;
          cnt <= cnt + 1'b1;
          if (cnt == SH'(W-1)) begin
            result    <= sel_hi ? mul_next[2*W-1:W] : mul_next[W-1:0];
            illegal   <= 1'b0;
            out_valid <= 1'b1;
            state     <= IDLE;
          end
        end
`ifdef ALU_SEQ_DIV_EN
        DIV: begin
          acc <= div_next;
          cnt <= cnt + 1'b1;
          if (cnt == SH'(W-1)) begin
            result    <= sel_hi ? div_next[2*W-1:W] : div_next[W-1:0];
            illegal   <= 1'b0;
            out_valid <= 1'b1;
            state     <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the single-cycle integer/float-sign ALU in the core's execute stage.
- Generalises datapath width.
- Replaces the funct one-hot select with an encoded opcode.
- Registers results behind a valid/ready interface.
- Adds iterative multi-cycle multiply (and optionally divide) driven by a small FSM; execute stalls on in_ready.

Parameters:
- W, 32, datapath width in bits; legal values 8..64, power of two.
- SH, $clog2(W), shift-amount width; derived, not overridden.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operation offered
- in_ready  out  1  block accepts operation this cycle
- op  in  4  opcode (encoding below)
- val1  in  W  operand 1
- val2  in  W  operand 2
- out_valid  out  1  result held valid
- out_ready  in  1  consumer takes result
- result  out  W  result
- illegal  out  1  qualifies result; high if op was unsupported

Behaviour:
- Reset: asynchronous on rst=1. State IDLE; out_valid=0, result=0, illegal=0; all iteration registers cleared. Reset mid-iteration aborts the operation with no output.
- Opcodes:
  - 0 ADD: val1+val2 mod 2^W.
  - 1 SUB: val1-val2 mod 2^W.
  - 2 SLL, 3 SRL, 4 SRA: shift amount is val2[SH-1:0]; upper bits ignored. SRA is arithmetic.
  - 5 FISPOS: {0.., ~val2[W-1]}.
  - 6 FISNEG: {0.., val2[W-1]}.
  - 7 FNEG: {~val2[W-1], val2[W-2:0]}.
  - 8 MUL: low W bits of unsigned product.
  - 9 MULHU: high W bits of unsigned product.
  - 10 DIVU, 11 REMU: macro-gated, see Optional Feature.
  - 12-15: illegal.
- Handshake:
  - in_ready = (state==IDLE) & (~out_valid | out_ready).
  - Transfer occurs when in_valid & in_ready.
  - The output stage holds result/illegal stable while out_valid & ~out_ready.
  - out_valid drops the cycle after out_ready unless a new result loads in the same edge.
- FSM states IDLE, MUL, DIV:
  - IDLE, single-cycle op (0-7) or illegal op accepted: result registered at the next edge, out_valid=1. Latency 1; back-to-back throughput 1/cycle when out_ready=1.
  - IDLE, MUL/MULHU accepted: latch operands, load a 2W accumulator, count=0, go to MUL.
  - MUL: radix-2 shift-add, one multiplier bit per cycle, W cycles. On count==W-1, write the selected half to result, out_valid=1, go to IDLE. Latency W+1 from accept to out_valid.
  - DIV: restoring, one quotient bit per cycle, W cycles, same completion rule. Latency W+1.
- Illegal op: result=0, illegal=1, latency 1.
- Boundaries:
  - Shift by 0: result = val1.
  - SRA of a negative value by W-1: all ones.
  - MUL with either operand 0: result 0, still W+1 cycles (no early-out).
- in_ready=0 throughout MUL/DIV. Input changes during iteration have no effect.

Optional Feature:
- Macro: ALU_SEQ_DIV_EN.
- Defined:
  - Opcodes 10/11 are legal and use the DIV state.
  - Divide by zero: DIVU result all ones, REMU result val1, illegal=0, same W+1 latency.
- Undefined:
  - DIV state and divider registers are not synthesised.
  - Opcodes 10/11 behave as illegal ops (result 0, illegal=1, latency 1).

Test Plan:
- Reset: assert rst mid-MUL (cycle 5 of 32) -> out_valid=0, result=0 immediately; in_ready=1 after release; no stale result appears.
- Single-cycle stream, W=32, out_ready=1:
  - ADD 0xFFFFFFFF+1 -> 0x00000000.
  - SRA 0x80000000 by val2=0x23 (amount 3) -> 0xF0000000.
  - FNEG 0x3F800000 -> 0xBF800000.
  - Each result one cycle after accept; in_ready stays high.
- MUL/MULHU 0xFFFFFFFF*0xFFFFFFFF -> low 0x00000001, high 0xFFFFFFFE; out_valid exactly 33 cycles after accept; in_ready low in between.
- Backpressure: out_ready=0 for 4 cycles after a SUB 5-7 -> result 0xFFFFFFFE held stable, in_ready=0; next op accepted the cycle out_ready rises.
- With ALU_SEQ_DIV_EN:
  - DIVU 100/7 -> 14.
  - REMU 100/7 -> 2.
  - DIVU x/0 -> 0xFFFFFFFF.
  - REMU 0x1234/0 -> 0x1234.
- Without ALU_SEQ_DIV_EN: op 10 -> result 0, illegal=1 after 1 cycle.
- Op 15 -> illegal=1 after 1 cycle.
- Repeat ADD/MUL checks with W=16: 0xFFFF*0xFFFF -> low 0x0001, high 0xFFFE; latency 17.
